// File: rtl/uart_receiver.sv
// 8N1 UART receiver with mid-bit sampling and a one-cycle received strobe.
// Define UART_RX_PARITY_EN to accept 8E1 frames and report even-parity errors.
module uart_receiver #(
    parameter int CLK_RATE  = 100000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       received,
    output logic       idle,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int          BIT_TICKS  = CLK_RATE / BAUD_RATE;
    localparam int          HALF_TICKS = BIT_TICKS / 2;
    localparam logic [31:0] BIT_LAST   = 32'(BIT_TICKS - 1);
    localparam logic [31:0] HALF_LAST  = 32'(HALF_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero.
    function automatic logic f_parity_err(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction
`endif

    state_t      r_state;
    state_t      w_next_state;
    logic        w_sample;
    logic        r_sync1;
    logic        r_sync2;
    logic        w_rx_s;
    logic [31:0] r_counter;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_data;
    logic        r_received;
    logic        r_idle;
    logic        r_frame_err;
    logic        r_parity_err;
`ifdef UART_RX_PARITY_EN
    logic        r_parity_bit;
`endif

    assign w_rx_s     = r_sync2;
    assign data       = r_data;
    assign received   = r_received;
    assign idle       = r_idle;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; w_sample marks the edge on which the line is sampled.
    always_comb begin
        w_next_state = r_state;
        w_sample     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_next_state = S_START;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_START: begin
                if (r_counter == HALF_LAST) begin
                    w_sample = 1'b1;
                    if (!w_rx_s) begin
                        w_next_state = S_DATA;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else begin
                    w_next_state = S_START;
                end
            end
            S_DATA: begin
                if (r_counter == BIT_LAST) begin
                    w_sample = 1'b1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_next_state = S_PARITY;
`else
                        w_next_state = S_STOP;
`endif
                    end else begin
                        w_next_state = S_DATA;
                    end
                end else begin
                    w_next_state = S_DATA;
                end
            end
            S_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (r_counter == BIT_LAST) begin
                    w_sample     = 1'b1;
                    w_next_state = S_STOP;
                end else begin
                    w_next_state = S_PARITY;
                end
`else
                w_next_state = S_IDLE;
`endif
            end
            S_STOP: begin
                if (r_counter == BIT_LAST) begin
                    w_sample = 1'b1;
                    if (w_rx_s) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_state = S_WAIT_HIGH;
                    end
                end else begin
                    w_next_state = S_STOP;
                end
            end
            S_WAIT_HIGH: begin
                if (w_rx_s) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_WAIT_HIGH;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Bit timer, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_counter    <= 32'd0;
            r_shift      <= 8'h00;
            r_bit_idx    <= 3'd0;
            r_data       <= 8'h00;
            r_received   <= 1'b0;
            r_idle       <= 1'b1;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_bit <= 1'b0;
`endif
        end else begin
            r_received <= 1'b0;
            r_idle     <= (w_next_state == S_IDLE);

            if ((w_next_state != r_state) || w_sample) begin
                r_counter <= 32'd0;
            end else begin
                r_counter <= r_counter + 32'd1;
            end

            if (r_state == S_START && w_sample) begin
                r_bit_idx <= 3'd0;
            end else if (r_state == S_DATA && w_sample) begin
                r_shift   <= {w_rx_s, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
`ifdef UART_RX_PARITY_EN
            if (r_state == S_PARITY && w_sample) begin
                r_parity_bit <= w_rx_s;
            end
`endif

            if (r_state == S_STOP && w_sample) begin
                r_data      <= r_shift;
                r_received  <= 1'b1;
                r_frame_err <= ~w_rx_s;
`ifdef UART_RX_PARITY_EN
                r_parity_err <= f_parity_err(r_shift, r_parity_bit);
`else
                r_parity_err <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: a frame-level transmitter model queues
// the expected byte/flags/latency, an independent monitor checks each strobe.
module tb_uart_receiver;

    localparam int BIT = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    // Strobe lands mid stop bit: (9.5 + PAR) bit times plus synchronizer lag.
    localparam int LAT_MIN = (9 + PAR) * BIT + BIT / 2 + 2;
    localparam int LAT_MAX = LAT_MIN + 1;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       received;
    logic       idle;
    logic       frame_err;
    logic       parity_err;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        int         t0;
    } exp_t;

    exp_t q[$];
    int   total;
    int   bad;
    int   cyc;
    logic prev_rcv;

    uart_receiver #(.CLK_RATE(16), .BAUD_RATE(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .received  (received),
        .idle      (idle),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (rst_n && received) begin
            check("no_consecutive_strobe", {31'd0, prev_rcv}, 32'd0);
            if (q.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                exp_t e;
                int   lat;
                e = q.pop_front();
                check("data", {24'd0, data}, {24'd0, e.d});
                check("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
                check("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
                lat = cyc - e.t0;
                total++;
                if (lat < LAT_MIN || lat > LAT_MAX) begin
                    bad++;
                    $display("FAIL latency: got=%0d expected=%0d..%0d", lat, LAT_MIN, LAT_MAX);
                end
            end
        end
        prev_rcv <= received;
    end

    task automatic hold_bit(input logic v);
        rx = v;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    // Transmitter model: drives one frame and records what the receiver must report.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        exp_t e;
        logic pbit;
        pbit = (^d) ^ par_flip;
        e.d  = d;
        e.fe = ~stop_bit;
        e.pe = (PAR == 1) ? (^{d, pbit}) : 1'b0;
        e.t0 = cyc;
        q.push_back(e);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        hold_bit(pbit);
`endif
        hold_bit(stop_bit);
    endtask

    task automatic gap(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        cyc      = 0;
        prev_rcv = 1'b0;
        rx       = 1'b1;
        rst_n    = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_data", {24'd0, data}, 32'h0);
        check("reset_received", {31'd0, received}, 32'd0);
        check("reset_idle", {31'd0, idle}, 32'd1);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_parity_err", {31'd0, parity_err}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        gap(8);

        // Clean frame.
        send_frame(8'hA5, 1'b1, 1'b0);
        gap(4);
        @(negedge clk);
        check("idle_after_a5", {31'd0, idle}, 32'd1);
        @(posedge clk); #1;

        // Start-bit glitch is rejected.
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        gap(40);
        @(negedge clk);
        check("glitch_idle", {31'd0, idle}, 32'd1);
        check("glitch_data_held", {24'd0, data}, 32'hA5);
        @(posedge clk); #1;

        // Stop bit low, line held low: waits for high before re-arming.
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("break_not_idle", {31'd0, idle}, 32'd0);
        @(posedge clk); #1;
        gap(6);
        send_frame(8'h01, 1'b1, 1'b0);
        gap(6);

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        gap(6);

        // Reset during data bit 4 discards the partial byte.
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(1'b0);
        rx = 1'b1;
        repeat (BIT / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_data", {24'd0, data}, 32'h0);
        check("midreset_idle", {31'd0, idle}, 32'd1);
        check("midreset_received", {31'd0, received}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        gap(40);
        send_frame(8'h5A, 1'b1, 1'b0);
        gap(4);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h81, 1'b1, 1'b1);
        gap(4);
        send_frame(8'h81, 1'b1, 1'b0);
        gap(4);
`endif

        // Loopback sweep of every byte value with random idle gaps.
        for (int b = 0; b < 256; b++) begin
            send_frame(8'(b), 1'b1, 1'b0);
            gap($urandom_range(0, 3));
        end

        // Random bytes with occasional framing (and parity) errors.
        for (int k = 0; k < 16; k++) begin
            logic [7:0] rb;
            logic       sb;
            logic       pf;
            rb = 8'($urandom_range(0, 255));
            sb = ($urandom_range(0, 3) != 0);
            pf = 1'($urandom_range(0, 1));
            send_frame(rb, sb, pf);
            if (!sb) begin
                rx = 1'b0;
                repeat ($urandom_range(1, 30)) @(posedge clk);
                #1;
                gap(4 + $urandom_range(0, 4));
            end else begin
                gap($urandom_range(0, 4));
            end
        end

        // Drain the scoreboard with a bounded wait.
        for (int w = 0; w < 500 && q.size() != 0; w++) @(posedge clk);
        gap(4);
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
